// File: rtl/pcs_pkg.sv
// Shared types and constants for the 1000BASE-X PCS receive path.
package pcs_pkg;

  // Synchronization FSM states, 4-bit encoding exposed on sync_state
  typedef enum logic [3:0] {
    LOSS_OF_SYNC     = 4'd0,
    COMMA_DETECT_1   = 4'd1,
    ACQUIRE_SYNC_1   = 4'd2,
    COMMA_DETECT_2   = 4'd3,
    ACQUIRE_SYNC_2   = 4'd4,
    COMMA_DETECT_3   = 4'd5,
    SYNC_ACQUIRED_1  = 4'd6,
    SYNC_ACQUIRED_2  = 4'd7,
    SYNC_ACQUIRED_2A = 4'd8,
    SYNC_ACQUIRED_3  = 4'd9,
    SYNC_ACQUIRED_3A = 4'd10,
    SYNC_ACQUIRED_4  = 4'd11,
    SYNC_ACQUIRED_4A = 4'd12
  } sync_state_e;

  // K28.5 code groups at negative and positive running disparity
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  // Seven-bit comma patterns found in bits a..g of a code group
  localparam logic [6:0] COMMA_P = 7'b0011111;
  localparam logic [6:0] COMMA_N = 7'b1100000;

  // True for every state in which the link is considered synchronized
  function automatic logic is_sync_ok(input sync_state_e s);
    return (s inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
                      SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A,
                      SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A});
  endfunction

endpackage

// File: rtl/pcs_comma_detect.sv
// Combinational comma flag: either polarity of the seven-bit comma in bits a..g.
module pcs_comma_detect
  import pcs_pkg::*;
(
  input  logic [9:0] i_code_group,
  output logic       o_comma
);

  logic [6:0] w_head;

  assign w_head  = i_code_group[9:3];
  assign o_comma = (w_head == COMMA_P) || (w_head == COMMA_N);

endmodule

// File: rtl/pcs_sync.sv
// PCS receive synchronization: comma qualification, rx_even tracking,
// sync_status generation and a saturating loss-of-sync event counter.
module pcs_sync
  import pcs_pkg::*;
#(
  parameter int unsigned GOOD_CGS_MAX = 3,
  parameter int unsigned LOSS_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  signal_detect,
  input  logic [9:0]            rx_code_group,
  input  logic                  rx_cg_valid,
  input  logic                  rx_cg_is_k,
  output logic [9:0]            rx_code_group_out,
  output logic                  sync_status,
  output logic                  rx_even,
  output logic [3:0]            sync_state,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  localparam logic [1:0] GOOD_MAX = 2'(GOOD_CGS_MAX);

  sync_state_e           r_state;
  logic                  r_rx_even;
  logic [1:0]            r_good_cgs;
  logic                  r_sync_status;
  logic [9:0]            r_code_group_out;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  sync_state_e           w_state_next;
  logic                  w_even_next;
  logic [1:0]            w_good_next;
  logic                  w_sync_next;
  logic                  w_loss_evt;
  logic                  w_comma;
  logic                  w_cgbad;
  logic                  w_data;

  pcs_comma_detect u_comma (
    .i_code_group (rx_code_group),
    .o_comma      (w_comma)
  );

  // A comma on an odd slot (rx_even already 1) is a misaligned comma.
  assign w_cgbad = !rx_cg_valid || (w_comma && r_rx_even);
  assign w_data  = rx_cg_valid && !rx_cg_is_k;

  // Next-state and entry actions; every (re)entry toggles rx_even except
  // the COMMA_DETECT states, which force the comma onto an even slot.
  always_comb begin
    w_state_next = r_state;
    w_even_next  = ~r_rx_even;
    w_good_next  = r_good_cgs;
    if (!signal_detect) begin
      w_state_next = LOSS_OF_SYNC;
      w_good_next  = 2'd0;
    end else begin
      unique case (r_state)
        LOSS_OF_SYNC: begin
          if (w_comma) begin
            w_state_next = COMMA_DETECT_1;
            w_even_next  = 1'b1;
          end
        end
        COMMA_DETECT_1: w_state_next = w_data ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
        COMMA_DETECT_2: w_state_next = w_data ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
        COMMA_DETECT_3: w_state_next = w_data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
        ACQUIRE_SYNC_1: begin
          if (w_cgbad) begin
            w_state_next = LOSS_OF_SYNC;
          end else if (w_comma && !r_rx_even) begin
            w_state_next = COMMA_DETECT_2;
            w_even_next  = 1'b1;
          end
        end
        ACQUIRE_SYNC_2: begin
          if (w_cgbad) begin
            w_state_next = LOSS_OF_SYNC;
          end else if (w_comma && !r_rx_even) begin
            w_state_next = COMMA_DETECT_3;
            w_even_next  = 1'b1;
          end
        end
        SYNC_ACQUIRED_1: begin
          if (w_cgbad) begin
            w_state_next = SYNC_ACQUIRED_2;
            w_good_next  = 2'd0;
          end
        end
        SYNC_ACQUIRED_2: begin
          if (w_cgbad) begin
            w_state_next = SYNC_ACQUIRED_3;
            w_good_next  = 2'd0;
          end else begin
            w_state_next = SYNC_ACQUIRED_2A;
            w_good_next  = 2'd1;
          end
        end
        SYNC_ACQUIRED_2A: begin
          if (w_cgbad) begin
            w_state_next = SYNC_ACQUIRED_3;
            w_good_next  = 2'd0;
          end else if (r_good_cgs == GOOD_MAX) begin
            w_state_next = SYNC_ACQUIRED_1;
            w_good_next  = 2'd0;
          end else begin
            w_good_next  = r_good_cgs + 2'd1;
          end
        end
        SYNC_ACQUIRED_3: begin
          if (w_cgbad) begin
            w_state_next = SYNC_ACQUIRED_4;
            w_good_next  = 2'd0;
          end else begin
            w_state_next = SYNC_ACQUIRED_3A;
            w_good_next  = 2'd1;
          end
        end
        SYNC_ACQUIRED_3A: begin
          if (w_cgbad) begin
            w_state_next = SYNC_ACQUIRED_4;
            w_good_next  = 2'd0;
          end else if (r_good_cgs == GOOD_MAX) begin
            w_state_next = SYNC_ACQUIRED_2;
            w_good_next  = 2'd0;
          end else begin
            w_good_next  = r_good_cgs + 2'd1;
          end
        end
        SYNC_ACQUIRED_4: begin
          if (w_cgbad) begin
            w_state_next = LOSS_OF_SYNC;
            w_good_next  = 2'd0;
          end else begin
            w_state_next = SYNC_ACQUIRED_4A;
            w_good_next  = 2'd1;
          end
        end
        SYNC_ACQUIRED_4A: begin
          if (w_cgbad) begin
            w_state_next = LOSS_OF_SYNC;
            w_good_next  = 2'd0;
          end else if (r_good_cgs == GOOD_MAX) begin
            w_state_next = SYNC_ACQUIRED_3;
            w_good_next  = 2'd0;
          end else begin
            w_good_next  = r_good_cgs + 2'd1;
          end
        end
        default: begin
          w_state_next = LOSS_OF_SYNC;
          w_good_next  = 2'd0;
        end
      endcase
    end
  end

  assign w_sync_next = is_sync_ok(w_state_next);
  assign w_loss_evt  = is_sync_ok(r_state) && (w_state_next == LOSS_OF_SYNC);

  // State, entry actions, loss counter and the output pipeline register
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state          <= LOSS_OF_SYNC;
      r_rx_even        <= 1'b0;
      r_good_cgs       <= 2'd0;
      r_sync_status    <= 1'b0;
      r_code_group_out <= 10'h000;
      r_loss_cnt       <= '0;
    end else begin
      r_state          <= w_state_next;
      r_rx_even        <= w_even_next;
      r_good_cgs       <= w_good_next;
      r_sync_status    <= w_sync_next;
      r_code_group_out <= rx_code_group;
      if (w_loss_evt && (r_loss_cnt != {LOSS_CNT_W{1'b1}})) begin
        r_loss_cnt <= r_loss_cnt + 1'b1;
      end
    end
  end

  assign rx_code_group_out = r_code_group_out;
  assign sync_status       = r_sync_status;
  assign rx_even           = r_rx_even;
  assign sync_state        = r_state;
  assign loss_cnt          = r_loss_cnt;

endmodule
